// File: rtl/ascon_pt_absorb.sv
// ascon_pt_absorb: ASCON-128 plaintext/ciphertext absorb stage.
// XORs each 64-bit block into the rate, emits ciphertext/plaintext and runs
// p6 between non-final blocks; the final block is padded and the state is
// handed to finalization without a permutation.
// Optional macro: ASCON_DOMAIN_SEP_EN applies the domain-separation bit
// (LSB of x4) to state_in when the operation starts.
module ascon_pt_absorb #(
  parameter int unsigned PB_LAT = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [319:0] state_in,
  input  logic [63:0]  blk_in,
  input  logic [2:0]   blk_bytes,
  input  logic         blk_last,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [319:0] perm_s,
  input  logic [319:0] perm_s_ret,
  output logic [63:0]  out_blk,
  output logic         out_valid,
  output logic [319:0] state_out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned CW = $clog2(PB_LAT + 1);

  typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [319:0]  s_q;
  logic          dec_q;
  logic [63:0]   sr, mask, pad, rate_nx, out_nx;
  logic          perm_end;

  assign sr       = s_q[319:256];
  assign perm_end = (cnt == CW'(PB_LAT));

  // S is the only state register; p6 input and the state output both read it,
  // so perm_s changes on exactly the edge that S does.
  assign perm_s    = s_q;
  assign state_out = s_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state and handshake/status outputs
  always_comb begin
    state_nx  = state;
    blk_ready = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ABSORB;
      end
      ABSORB: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nx = blk_last ? DONE : PERM;
      end
      PERM: begin
        if (perm_end) state_nx = ABSORB;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Data-byte mask, 10* pad word and the new rate/output words.
  // A full block is the n=8 case (mask all ones, no pad), so encrypt and
  // decrypt each reduce to one expression covering both block kinds.
  always_comb begin
    mask = '1;
    pad  = '0;
    if (blk_last) begin
      mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {blk_bytes, 3'b000});
      pad  = 64'h80 << {3'd7 - blk_bytes, 3'b000};
    end
    out_nx = (sr ^ blk_in) & mask;
    if (dec_q) rate_nx = (blk_in & mask) | ((sr & ~mask) ^ pad);
    else       rate_nx = sr ^ (blk_in & mask) ^ pad;
  end

  // State, round counter and output block registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      dec_q     <= 1'b0;
      cnt       <= '0;
      out_blk   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef ASCON_DOMAIN_SEP_EN
            s_q <= state_in ^ 320'h1;
`else
            s_q <= state_in;
`endif
            dec_q <= decrypt;
          end
        end
        ABSORB: begin
          if (blk_valid) begin
            s_q[319:256] <= rate_nx;
            out_blk      <= out_nx;
            out_valid    <= !(blk_last && (blk_bytes == 3'd0));
            cnt          <= '0;
          end
        end
        PERM: begin
          cnt <= cnt + 1'b1;
          if (perm_end) s_q <= perm_s_ret;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_pt_absorb.sv
// Directed testbench for ascon_pt_absorb with a 6-stage behavioural p6 model.
module tb_ascon_pt_absorb;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         decrypt;
  logic [319:0] state_in;
  logic [63:0]  blk_in;
  logic [2:0]   blk_bytes;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [319:0] perm_s;
  logic [319:0] perm_s_ret;
  logic [63:0]  out_blk;
  logic         out_valid;
  logic [319:0] state_out;
  logic         done;
  logic         busy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

`ifdef ASCON_DOMAIN_SEP_EN
  localparam logic [319:0] DS = 320'h1;
`else
  localparam logic [319:0] DS = '0;
`endif
  localparam logic [255:0] DSC  = DS[255:0];
  localparam logic [319:0] K    = {5{64'h5A5A5A5A5A5A5A5A}};
  localparam logic [255:0] KC   = K[255:0];
  localparam logic [255:0] CAP  = {4{64'h0F0E0D0C0B0A0908}};
  localparam logic [255:0] CAP2 = {4{64'h1020304050607080}};
  localparam logic [319:0] SABS = {64'hFEDCBA9876543210, CAP ^ DSC};

  always #5 clk = ~clk;

  ascon_pt_absorb #(.PB_LAT(6)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .state_in(state_in), .blk_in(blk_in), .blk_bytes(blk_bytes),
    .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .perm_s(perm_s), .perm_s_ret(perm_s_ret), .out_blk(out_blk),
    .out_valid(out_valid), .state_out(state_out), .done(done), .busy(busy)
  );

  // p6 stand-in: six registered stages, result = input ^ K
  logic [319:0] pipe [6];
  always @(posedge clk) begin
    pipe[0] <= perm_s ^ K;
    for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
  end
  assign perm_s_ret = pipe[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [319:0] si, input logic d);
    state_in = si;
    decrypt  = d;
    start    = 1'b1;
    step();
    start    = 1'b0;
    state_in = '0;
  endtask

  task automatic send(input logic [63:0] b, input logic last, input logic [2:0] n);
    int unsigned t = 0;
    while (blk_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("ready_wait", blk_ready, 1);
    blk_in    = b;
    blk_last  = last;
    blk_bytes = n;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    blk_in    = 64'hDEADBEEFCAFEF00D;
    blk_last  = 1'b0;
    blk_bytes = 3'd5;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; state_in = '0;
    blk_in = '0; blk_bytes = '0; blk_last = 1'b0; blk_valid = 1'b0;

    // reset state
    step(); step();
    chk("rst_ready", blk_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_perm_s", perm_s, 0);
    chk("rst_out_blk", out_blk, 0);
    rst = 1'b0;
    step();

    // domain separation on a zero state
    go('0, 1'b0);
    chk("ds_state", state_out, DS);
    chk("ds_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // encrypt: one full block, permutation, then empty last block
    go({64'h0123456789ABCDEF, CAP}, 1'b0);
    chk("e1_load", state_out, {64'h0123456789ABCDEF, CAP} ^ DS);
    chk("e1_ready", blk_ready, 1);
    send(64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0);
    chk("e1_out", out_blk, 64'hFEDCBA9876543210);
    chk("e1_ovalid", out_valid, 1);
    chk("e1_perm_s", perm_s, SABS);
    chk("e1_ready_lo", blk_ready, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin start = 1'b1; state_in = '1; end
      if (k == 2) begin start = 1'b0; state_in = '0; end
      step();
      chk("e1_perm_hold", state_out, SABS);
      chk("e1_perm_ready", blk_ready, 0);
      chk("e1_perm_ov", out_valid, 0);
    end
    step();
    chk("e1_capture", state_out, SABS ^ K);
    chk("e1_perm_s2", perm_s, SABS ^ K);
    chk("e1_ready_hi", blk_ready, 1);
    send(64'h0123456789ABCDEF, 1'b1, 3'd0);
    chk("e1_pad_ov", out_valid, 0);
    chk("e1_pad_done", done, 1);
    chk("e1_pad_state", state_out, {64'h2486E0C22C0E684A, (CAP ^ DSC) ^ KC});
    step();
    chk("e1_done_lo", done, 0);
    chk("e1_idle_busy", busy, 0);
    chk("e1_final_hold", state_out, {64'h2486E0C22C0E684A, (CAP ^ DSC) ^ KC});

    // encrypt: partial last block, 3 bytes (trailing input bytes must be masked)
    go({64'h0, CAP2}, 1'b0);
    send(64'hAABBCCDDEEFF0011, 1'b1, 3'd3);
    chk("e2_out", out_blk, 64'hAABBCC0000000000);
    chk("e2_ovalid", out_valid, 1);
    chk("e2_state", state_out, {64'hAABBCC8000000000, CAP2 ^ DSC});
    chk("e2_done", done, 1);
    step();
    chk("e2_ov_lo", out_valid, 0);
    chk("e2_no_perm", state_out, {64'hAABBCC8000000000, CAP2 ^ DSC});
    chk("e2_busy", busy, 0);

    // decrypt: partial last block, 3 bytes
    go({64'h1111111111111111, CAP}, 1'b1);
    send(64'h2233445566778899, 1'b1, 3'd3);
    chk("d1_out", out_blk, 64'h3322550000000000);
    chk("d1_ovalid", out_valid, 1);
    chk("d1_state", state_out, {64'h2233449111111111, CAP ^ DSC});
    step();

    // decrypt full block, then reset in the middle of the permutation
    go({64'h1111111111111111, CAP}, 1'b1);
    send(64'h0123456789ABCDEF, 1'b0, 3'd0);
    chk("d2_out", out_blk, 64'h1032547698BADCFE);
    chk("d2_state", state_out, {64'h0123456789ABCDEF, CAP ^ DSC});
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_state", state_out, 0);
    chk("ab_ovalid", out_valid, 0);
    repeat (6) step();
    chk("ab_late_state", state_out, 0);
    chk("ab_late_busy", busy, 0);
    chk("ab_late_ready", blk_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ascon_pt_absorb.md
Name: ascon_pt_absorb

Overview:
- Plaintext/ciphertext processing stage of the ASCON-128 datapath; sits directly upstream of the 6-round pb permutation (p6) and consumes its result.
- Per 64-bit rate block: XOR into state rate S[319:256], emit ciphertext or plaintext, and launch p6 on the updated state for every non-final block.
- On the final padded block: apply 10* padding, emit the last output bytes, and hand the full 320-bit state to finalization without permuting.

Parameters:
- PB_LAT, 6: clk edges from a change on perm_s to valid perm_s_ret (one per registered round).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; loads state_in; ignored unless IDLE
- decrypt  in  1  sampled with start; 0 = encrypt, 1 = decrypt
- state_in  in  320  state after associated-data processing
- blk_in  in  64  data block, big-endian bytes (byte i = bits [63-8i -: 8])
- blk_bytes  in  3  valid bytes of final block, 0..7; ignored when blk_last=0
- blk_last  in  1  marks final block
- blk_valid  in  1  block available
- blk_ready  out  1  block accepted on the edge where blk_valid & blk_ready
- perm_s  out  320  registered; drives p6 s_in
- perm_s_ret  in  320  p6 s_out
- out_blk  out  64  ciphertext (encrypt) or plaintext (decrypt); non-data bytes are zero
- out_valid  out  1  one-cycle qualifier for out_blk
- state_out  out  320  current state register S
- done  out  1  one-cycle pulse; state_out is final
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; S, perm_s, out_blk = 0; blk_ready, out_valid, done, busy = 0. A reset in any state, including mid-PERM, aborts the operation; the perm_s_ret value in flight is discarded.
- perm_s mirrors S and is updated on the same edge as S. state_out = S.
- IDLE: on start, S <= state_in, decrypt latched, go ABSORB. blk_ready is 0.
- ABSORB: blk_ready=1. On handshake, with Sr = S[319:256], M = data-byte mask, P = pad word:
  - Non-last block: M = all ones, P = 0. Encrypt: Sr <= Sr^blk_in, out_blk <= Sr^blk_in. Decrypt: out_blk <= Sr^blk_in, Sr <= blk_in. Go to PERM with cnt=0.
  - Last block, n = blk_bytes: M = top n bytes set; P = 0x80 in byte n. out_blk <= (Sr^blk_in)&M. Encrypt: Sr <= Sr^(blk_in&M)^P. Decrypt: Sr <= (blk_in&M) | ((Sr&~M)^P). Go to DONE.
  - out_valid pulses on the cycle after the handshake, except for a last block with n=0 (pure padding block, no output).
  - A message whose length is a multiple of 8 bytes is sent as full non-last blocks followed by a last block with blk_bytes=0.
- PERM: blk_ready=0. cnt increments every cycle. On the edge where cnt==PB_LAT, S <= perm_s_ret and the block returns to ABSORB.
  - Timing: a block accepted at edge E0 has its permuted state captured at E0+PB_LAT+1, and blk_ready is high again in the cycle after that edge.
  - Sustained throughput is one block per PB_LAT+2 cycles.
- DONE: done=1 for exactly one cycle; S holds; next state IDLE.
- Other rules: start outside IDLE is ignored. blk_valid outside ABSORB has no effect. blk_in may change freely while blk_ready=0.

Optional Feature:
- ASCON_DOMAIN_SEP_EN defined: on start, S <= state_in ^ 320'h1, i.e. the domain-separation bit at LSB of x4 is applied here.
- Not defined: S <= state_in unchanged; upstream applies domain separation.

Test Plan:
- Reset: assert rst two cycles -> blk_ready=0, busy=0, done=0, out_valid=0, perm_s=0. Repeat with ASCON_DOMAIN_SEP_EN defined and state_in=0 -> after start, state_out=320'h1.
- Encrypt, non-last block: Sr=64'h0123456789ABCDEF, blk_in=64'hFFFFFFFFFFFFFFFF -> out_blk=64'hFEDCBA9876543210 with one-cycle out_valid; perm_s rate equals same value; with a behavioural 6-cycle p6 model, S is captured exactly 7 edges after acceptance; blk_ready re-asserts next cycle.
- Encrypt, empty last block: Sr=0, blk_last=1, blk_bytes=0 -> no out_valid; Sr=64'h8000000000000000; done pulses one cycle after the handshake; then IDLE with busy=0.
- Encrypt, partial last block: Sr=0, blk_in=64'hAABBCC0000000000, blk_bytes=3 -> out_blk=64'hAABBCC0000000000; Sr=64'hAABBCC8000000000; capacity unchanged; no permutation launched.
- Decrypt, partial last block: Sr=64'h1111111111111111, blk_in=64'h2233440000000000, blk_bytes=3 -> out_blk=64'h3322550000000000; Sr=64'h2233449111111111.
- Abort and ignored start: rst at PERM cycle 3 -> IDLE next cycle, busy=0, late perm_s_ret not captured, S=0. Separately, start pulsed during PERM -> ignored; S and cnt are unaffected.
